// File: rtl/pe_gen2_pkg.sv
// Shared types and geometry for the gen2 row-stationary PE: state encoding, config word layout,
// spad sizes and index widths.
package pe_gen2_pkg;

  localparam int DATA_BITS  = 32;
  localparam int ELEM_W     = 8;
  localparam int PSUM_W     = 32;
  localparam int MAX_RS     = 4;
  localparam int LANES      = DATA_BITS / ELEM_W;
  localparam int MAX_Q      = LANES;
  localparam int MAX_P      = 4;
  localparam int MAX_F      = 16;
  localparam int IFMAP_LEN  = 16;
  localparam int FILTER_LEN = 64;
  localparam int PSUM_LEN   = 4;
  localparam bit ZP_FLIP    = 1'b1;

  localparam int Q_W   = $clog2(MAX_Q);
  localparam int P_W   = $clog2(MAX_P);
  localparam int RS_W  = $clog2(MAX_RS);
  localparam int F_W   = $clog2(MAX_F);
  localparam int STR_W = $clog2(MAX_RS);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam int IFA_W = $clog2(IFMAP_LEN);
  localparam int FLA_W = $clog2(FILTER_LEN);
  localparam int PSA_W = $clog2(PSUM_LEN);

  typedef enum logic [2:0] {
    IDLE,
    READ_FILTER,
    READ_IFMAP,
    READ_IPSUM,
    CONV,
    WRITE_OPSUM
  } state_e;

  typedef struct packed {
    logic [STR_W-1:0] stride_m1;
    logic             mode;
    logic [RS_W-1:0]  rs_m1;
    logic [P_W-1:0]   p_m1;
    logic [F_W-1:0]   f_m1;
    logic [Q_W-1:0]   q_m1;
  } cfg_t;

  localparam int CFG_W = $bits(cfg_t);

  // Ifmap arrives as unsigned bytes; flipping the MSB recentres it to two's complement.
  function automatic logic [ELEM_W-1:0] ifmap_decode(input logic [ELEM_W-1:0] raw);
    return ZP_FLIP ? {~raw[ELEM_W-1], raw[ELEM_W-2:0]} : raw;
  endfunction

endpackage

// File: rtl/pe_gen2_mac.sv
// Single signed multiply-accumulate: ELEM_W x ELEM_W product added into a PSUM_W accumulator,
// wrapping modulo 2^PSUM_W.
module pe_gen2_mac
  import pe_gen2_pkg::*;
(
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  input  logic signed [PSUM_W-1:0] acc_in,
  output logic signed [PSUM_W-1:0] acc_out
);

  logic signed [2*ELEM_W-1:0] prod;

  function automatic logic signed [PSUM_W-1:0] wrap_acc(input logic signed [PSUM_W-1:0] acc,
                                                        input logic signed [2*ELEM_W-1:0] p);
    logic signed [PSUM_W-1:0] p_ext;
    p_ext = {{(PSUM_W-2*ELEM_W){p[2*ELEM_W-1]}}, p};
    return acc + p_ext;
  endfunction

  always_comb begin
    prod    = a * b;
    acc_out = wrap_acc(acc_in, prod);
  end

endmodule

// File: rtl/pe_gen2.sv
// Gen2 row-stationary PE: loads filter/ifmap/psum spads, runs one MAC per cycle over the window,
// streams psums out and repeats for F output columns, sliding the ifmap window by the stride.
module pe_gen2
  import pe_gen2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PE_en,
  input  logic [CFG_W-1:0]     i_config,
  input  logic [DATA_BITS-1:0] ifmap,
  input  logic [DATA_BITS-1:0] filter,
  input  logic [DATA_BITS-1:0] ipsum,
  input  logic                 ifmap_valid,
  input  logic                 filter_valid,
  input  logic                 ipsum_valid,
  input  logic                 opsum_ready,
  output logic [DATA_BITS-1:0] opsum,
  output logic                 ifmap_ready,
  output logic                 filter_ready,
  output logic                 ipsum_ready,
  output logic                 opsum_valid,
  output logic                 done
);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] f_cnt_q, f_cnt_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] k_cnt_q, k_cnt_d;
  logic [CNT_W-1:0] w_idx_q, w_idx_d;
  logic [PSA_W-1:0] p_idx_q, p_idx_d;
  logic [PSA_W-1:0] out_idx_q, out_idx_d;
  logic [F_W-1:0]   col_cnt_q, col_cnt_d;
  logic             done_q, done_d;

  logic [ELEM_W-1:0] filter_spad_q [FILTER_LEN];
  logic [ELEM_W-1:0] filter_spad_d [FILTER_LEN];
  logic [ELEM_W-1:0] ifmap_spad_q  [IFMAP_LEN];
  logic [ELEM_W-1:0] ifmap_spad_d  [IFMAP_LEN];
  logic [PSUM_W-1:0] psum_spad_q   [PSUM_LEN];
  logic [PSUM_W-1:0] psum_spad_d   [PSUM_LEN];

  logic [CNT_W-1:0] q_n, p_n, rs_n, s_n, w_n, n_n, qs_n, src;
  logic [PSUM_W-1:0] mac_out;

  always_comb begin
    q_n  = CNT_W'(cfg_q.q_m1) + CNT_W'(1);
    p_n  = CNT_W'(cfg_q.p_m1) + CNT_W'(1);
    rs_n = CNT_W'(cfg_q.rs_m1) + CNT_W'(1);
    s_n  = (CNT_W'(cfg_q.stride_m1) + CNT_W'(1) < rs_n) ?
           CNT_W'(cfg_q.stride_m1) + CNT_W'(1) : rs_n;
    w_n  = q_n * rs_n;
    n_n  = p_n * w_n;
    qs_n = q_n * s_n;
  end

  pe_gen2_mac u_mac (
    .a      (filter_spad_q[FLA_W'(k_cnt_q)]),
    .b      (ifmap_spad_q[IFA_W'(w_idx_q)]),
    .acc_in (psum_spad_q[p_idx_q]),
    .acc_out(mac_out)
  );

  assign filter_ready = (state_q == READ_FILTER);
  assign ifmap_ready  = (state_q == READ_IFMAP);
  assign ipsum_ready  = (state_q == READ_IPSUM) && !cfg_q.mode;
  assign opsum_valid  = (state_q == WRITE_OPSUM);
  assign opsum        = psum_spad_q[out_idx_q];
  assign done         = done_q;

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    f_cnt_d       = f_cnt_q;
    i_cnt_d       = i_cnt_q;
    k_cnt_d       = k_cnt_q;
    w_idx_d       = w_idx_q;
    p_idx_d       = p_idx_q;
    out_idx_d     = out_idx_q;
    col_cnt_d     = col_cnt_q;
    done_d        = 1'b0;
    filter_spad_d = filter_spad_q;
    ifmap_spad_d  = ifmap_spad_q;
    psum_spad_d   = psum_spad_q;
    src           = '0;

    unique case (state_q)
      IDLE: begin
        if (PE_en) begin
          cfg_d     = cfg_t'(i_config);
          f_cnt_d   = '0;
          i_cnt_d   = '0;
          k_cnt_d   = '0;
          w_idx_d   = '0;
          p_idx_d   = '0;
          out_idx_d = '0;
          col_cnt_d = '0;
          state_d   = READ_FILTER;
        end
      end

      READ_FILTER: begin
        if (filter_valid) begin
          for (int l = 0; l < LANES; l++) begin
            if (CNT_W'(l) < q_n)
              filter_spad_d[FLA_W'(f_cnt_q + CNT_W'(l))] = filter[l*ELEM_W +: ELEM_W];
          end
          f_cnt_d = f_cnt_q + q_n;
          if (f_cnt_q + q_n == n_n) state_d = READ_IFMAP;
        end
      end

      READ_IFMAP: begin
        if (ifmap_valid) begin
          for (int l = 0; l < LANES; l++) begin
            if (CNT_W'(l) < q_n)
              ifmap_spad_d[IFA_W'(i_cnt_q + CNT_W'(l))] = ifmap_decode(ifmap[l*ELEM_W +: ELEM_W]);
          end
          i_cnt_d = i_cnt_q + q_n;
          if (i_cnt_q + q_n == w_n) begin
            p_idx_d = '0;
            state_d = READ_IPSUM;
          end
        end
      end

      READ_IPSUM: begin
        if (cfg_q.mode) begin
          for (int j = 0; j < PSUM_LEN; j++) begin
            if (CNT_W'(j) < p_n) psum_spad_d[j] = '0;
          end
          k_cnt_d = '0;
          w_idx_d = '0;
          p_idx_d = '0;
          state_d = CONV;
        end else if (ipsum_valid) begin
          psum_spad_d[p_idx_q] = ipsum;
          if (p_idx_q == PSA_W'(cfg_q.p_m1)) begin
            k_cnt_d = '0;
            w_idx_d = '0;
            p_idx_d = '0;
            state_d = CONV;
          end else begin
            p_idx_d = p_idx_q + PSA_W'(1);
          end
        end
      end

      CONV: begin
        psum_spad_d[p_idx_q] = mac_out;
        k_cnt_d = k_cnt_q + CNT_W'(1);
        // w_idx/p_idx track k % W and k / W without a divider
        if (w_idx_q == w_n - CNT_W'(1)) begin
          w_idx_d = '0;
          p_idx_d = p_idx_q + PSA_W'(1);
        end else begin
          w_idx_d = w_idx_q + CNT_W'(1);
        end
        if (k_cnt_q == n_n - CNT_W'(1)) begin
          out_idx_d = '0;
          state_d   = WRITE_OPSUM;
        end
      end

      WRITE_OPSUM: begin
        if (opsum_ready) begin
          if (out_idx_q == PSA_W'(cfg_q.p_m1)) begin
            out_idx_d = '0;
            if (col_cnt_q == cfg_q.f_m1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              col_cnt_d = col_cnt_q + F_W'(1);
              // slide the window: keep the overlap, refetch only q*S elements
              for (int j = 0; j < IFMAP_LEN; j++) begin
                src = CNT_W'(j) + qs_n;
                ifmap_spad_d[j] = (src < CNT_W'(IFMAP_LEN)) ? ifmap_spad_q[IFA_W'(src)] : '0;
              end
              i_cnt_d = w_n - qs_n;
              state_d = READ_IFMAP;
            end
          end else begin
            out_idx_d = out_idx_q + PSA_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      f_cnt_q   <= '0;
      i_cnt_q   <= '0;
      k_cnt_q   <= '0;
      w_idx_q   <= '0;
      p_idx_q   <= '0;
      out_idx_q <= '0;
      col_cnt_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < FILTER_LEN; i++) filter_spad_q[i] <= '0;
      for (int i = 0; i < IFMAP_LEN; i++)  ifmap_spad_q[i]  <= '0;
      for (int i = 0; i < PSUM_LEN; i++)   psum_spad_q[i]   <= '0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      f_cnt_q       <= f_cnt_d;
      i_cnt_q       <= i_cnt_d;
      k_cnt_q       <= k_cnt_d;
      w_idx_q       <= w_idx_d;
      p_idx_q       <= p_idx_d;
      out_idx_q     <= out_idx_d;
      col_cnt_q     <= col_cnt_d;
      done_q        <= done_d;
      filter_spad_q <= filter_spad_d;
      ifmap_spad_q  <= ifmap_spad_d;
      psum_spad_q   <= psum_spad_d;
    end
  end

endmodule

// File: tb/tb_pe_gen2.sv
// Directed bench for pe_gen2: hand-computed opsums for several configurations, handshake
// stalls, psum-init mode, stride, mid-run reset and accumulator wrap.
module tb_pe_gen2;

  logic        clk;
  logic        rst;
  logic        PE_en;
  logic [12:0] i_config;
  logic [31:0] ifmap, filter, ipsum;
  logic        ifmap_valid, filter_valid, ipsum_valid;
  logic        opsum_ready;
  logic [31:0] opsum;
  logic        ifmap_ready, filter_ready, ipsum_ready, opsum_valid, done;

  int n_assert = 0;
  int n_fail   = 0;

  pe_gen2 dut (
    .clk         (clk),
    .rst         (rst),
    .PE_en       (PE_en),
    .i_config    (i_config),
    .ifmap       (ifmap),
    .filter      (filter),
    .ipsum       (ipsum),
    .ifmap_valid (ifmap_valid),
    .filter_valid(filter_valid),
    .ipsum_valid (ipsum_valid),
    .opsum_ready (opsum_ready),
    .opsum       (opsum),
    .ifmap_ready (ifmap_ready),
    .filter_ready(filter_ready),
    .ipsum_ready (ipsum_ready),
    .opsum_valid (opsum_valid),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {stride_m1[1:0], mode, rs_m1[1:0], p_m1[1:0], F_m1[3:0], q_m1[1:0]}
  function automatic logic [12:0] mk_cfg(int str, int md, int rs, int p, int f, int q);
    return {2'(str), 1'(md), 2'(rs), 2'(p), 4'(f), 2'(q)};
  endfunction

  function automatic logic rdy(int ch);
    case (ch)
      0:       return filter_ready;
      1:       return ifmap_ready;
      default: return ipsum_ready;
    endcase
  endfunction

  task automatic start(input logic [12:0] cfg);
    i_config = cfg;
    PE_en    = 1'b1;
    tick();
    PE_en    = 1'b0;
  endtask

  // ch: 0 filter, 1 ifmap, 2 ipsum
  task automatic send(input int ch, input logic [31:0] d);
    int t = 0;
    case (ch)
      0:       begin filter = d; filter_valid = 1'b1; end
      1:       begin ifmap  = d; ifmap_valid  = 1'b1; end
      default: begin ipsum  = d; ipsum_valid  = 1'b1; end
    endcase
    while (!rdy(ch) && t < 100) begin tick(); t++; end
    chk1($sformatf("ready_ch%0d", ch), rdy(ch), 1'b1);
    tick();
    case (ch)
      0:       filter_valid = 1'b0;
      1:       ifmap_valid  = 1'b0;
      default: ipsum_valid  = 1'b0;
    endcase
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!opsum_valid && t < 200) begin tick(); t++; end
  endtask

  task automatic recv(input string tag, input logic [31:0] exp);
    wait_valid();
    chk1({tag, "_vld"}, opsum_valid, 1'b1);
    chk32(tag, opsum, exp);
    opsum_ready = 1'b1;
    tick();
    opsum_ready = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk1({tag, "_done"}, done, 1'b1);
    tick();
    chk1({tag, "_done_pulse"}, done, 1'b0);
    chk1({tag, "_idle"}, filter_ready, 1'b0);
  endtask

  // filter 1,2,3; ifmap stored 1,2,3 then 4; ipsum 10 then 0 -> 24, 20
  task automatic run_t1(input bit hold);
    start(mk_cfg(0, 0, 2, 0, 1, 0));
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
    send(1, 32'd129); send(1, 32'd130); send(1, 32'd131);
    send(2, 32'd10);
    if (hold) begin
      wait_valid();
      repeat (5) begin
        tick();
        chk1("t4_hold_vld", opsum_valid, 1'b1);
        chk32("t4_hold_opsum", opsum, 32'd24);
      end
    end
    recv("t1_col0", 32'd24);
    send(1, 32'd132);
    chk1("t1_col1_single_beat", ifmap_ready, 1'b0);
    send(2, 32'd0);
    recv("t1_col1", 32'd20);
    check_done("t1");
  endtask

  initial begin
    int n;
    rst = 1'b1; PE_en = 1'b0; i_config = '0;
    ifmap = '0; filter = '0; ipsum = '0;
    ifmap_valid = 1'b0; filter_valid = 1'b0; ipsum_valid = 1'b0; opsum_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk1("rst_filter_ready", filter_ready, 1'b0);
    chk1("rst_ifmap_ready", ifmap_ready, 1'b0);
    chk1("rst_ipsum_ready", ipsum_ready, 1'b0);
    chk1("rst_opsum_valid", opsum_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_opsum", opsum, 32'd0);

    run_t1(1'b0);

    run_t1(1'b1);

    // q=4, p=2, rs=2, F=1: W=8, N=16
    start(mk_cfg(0, 0, 1, 1, 0, 3));
    send(0, 32'h04030201); send(0, 32'h08070605);
    send(0, 32'h00000080); send(0, 32'h7F000000);
    send(1, 32'h84838281); send(1, 32'h7C7D7E7F);
    send(2, 32'd100); send(2, 32'hFFFFFFFF);
    n = 0;
    while (!opsum_valid && n < 100) begin tick(); n++; end
    chk32("t2_conv_cycles", n, 32'd16);
    recv("t2_psum0", 32'h0000003C);
    recv("t2_psum1", 32'hFFFFFD83);
    check_done("t2");

    // psum-init mode, stride 2 over rs=3: windows {1,2,3} then {3,4,5}
    ipsum = 32'h12345678; ipsum_valid = 1'b1;
    start(mk_cfg(1, 1, 2, 0, 1, 0));
    chk1("t3_ipsum_ready_fill", ipsum_ready, 1'b0);
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
    send(1, 32'h81); send(1, 32'h82); send(1, 32'h83);
    chk1("t3_ipsum_ready_init", ipsum_ready, 1'b0);
    chk1("t3_ifmap_ready_init", ifmap_ready, 1'b0);
    ipsum_valid = 1'b1;
    recv("t3_col0", 32'd14);
    send(1, 32'h84);
    chk1("t3_second_beat_needed", ifmap_ready, 1'b1);
    send(1, 32'h85);
    chk1("t3_ipsum_ready_col1", ipsum_ready, 1'b0);
    recv("t3_col1", 32'd26);
    check_done("t3");
    ipsum_valid = 1'b0;

    // reset in the middle of CONV
    start(mk_cfg(0, 0, 2, 0, 1, 0));
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
    send(1, 32'd129); send(1, 32'd130); send(1, 32'd131);
    send(2, 32'd10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("t5_filter_ready", filter_ready, 1'b0);
    chk1("t5_ifmap_ready", ifmap_ready, 1'b0);
    chk1("t5_ipsum_ready", ipsum_ready, 1'b0);
    chk1("t5_opsum_valid", opsum_valid, 1'b0);
    chk1("t5_done", done, 1'b0);
    chk32("t5_opsum", opsum, 32'd0);
    tick();
    chk1("t5_still_idle", opsum_valid, 1'b0);
    chk1("t5_no_done", done, 1'b0);
    run_t1(1'b0);

    // accumulator wrap: 0x7FFFFFFF + 1*1
    start(mk_cfg(0, 0, 0, 0, 0, 0));
    send(0, 32'd1);
    send(1, 32'd129);
    send(2, 32'h7FFFFFFF);
    recv("t6_wrap", 32'h80000000);
    check_done("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
